// File: rtl/fp32_iter_div_sqrt_if.sv
// Request/response bundle between the FP div/sqrt allocation controller and one
// iterative datapath core: operands plus start pulse out, finished/result back.
interface fp32_iter_div_sqrt_if;
  logic        req;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic        is_divide;
  logic        finished;
  logic [31:0] result;

  modport master (output req, lhs, rhs, is_divide, input finished, result);
  modport slave  (input req, lhs, rhs, is_divide, output finished, result);
endinterface

// File: rtl/fp32_iter_div_sqrt.sv
// Iterative binary32 divide / square root, digit recurrence with RNE rounding.
// Optional FP_DIVSQRT_EARLY_OUT_EN skips the loop for special results and divide by +-1.
module fp32_iter_div_sqrt #(
  parameter int RADIX_BITS = 1
) (
  input logic                 clk,
  input logic                 rst,
  fp32_iter_div_sqrt_if.slave ctrl_io
);
  localparam int         ITER_CYCLES = (27 + RADIX_BITS - 1) / RADIX_BITS;
  localparam logic [4:0] LAST_CNT    = 5'(ITER_CYCLES - 1);
  localparam logic [31:0] QNAN       = 32'h7FC00000;

  typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, DONE} state_e;

  state_e            state_q, state_d;
  logic [31:0]       lhs_q, rhs_q, specVal_q, result_q;
  logic              isDiv_q, sign_q, special_q, finished_q;
  logic [4:0]        cnt_q;
  logic [28:0]       rem_q;
  logic [26:0]       quot_q;
  logic [53:0]       rad_q;
  logic [23:0]       divisor_q;
  logic signed [9:0] exp_q;

  logic [7:0]        ea, eb;
  logic              sa, sb, aZero, aInf, aNaN, bZero, bInf, bNaN, sqrtOdd;
  logic [23:0]       ma, mb;
  logic signed [9:0] expSqrtUnb, expUnp;
  logic              specialUnp, earlyOut;
  logic [31:0]       specValUnp;

  // Operand classification; subnormals count as zero.
  assign ea    = lhs_q[30:23];
  assign eb    = rhs_q[30:23];
  assign sa    = lhs_q[31];
  assign sb    = rhs_q[31];
  assign aZero = (ea == 8'd0);
  assign bZero = (eb == 8'd0);
  assign aInf  = (ea == 8'hFF) && (lhs_q[22:0] == 23'd0);
  assign bInf  = (eb == 8'hFF) && (rhs_q[22:0] == 23'd0);
  assign aNaN  = (ea == 8'hFF) && (lhs_q[22:0] != 23'd0);
  assign bNaN  = (eb == 8'hFF) && (rhs_q[22:0] != 23'd0);
  assign ma    = {1'b1, lhs_q[22:0]};
  assign mb    = {1'b1, rhs_q[22:0]};

  // An odd unbiased exponent (even biased one) doubles the radicand so the root lands in [1,2).
  assign sqrtOdd    = ~ea[0];
  assign expSqrtUnb = $signed({2'b00, ea}) - 10'sd127;
  assign expUnp     = isDiv_q ? ($signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127)
                              : ((expSqrtUnb >>> 1) + 10'sd127);

  always_comb begin
    specialUnp = 1'b0;
    specValUnp = 32'h0;
    earlyOut   = 1'b0;
    if (isDiv_q) begin
      if (aNaN || bNaN || (aZero && bZero) || (aInf && bInf)) begin
        specialUnp = 1'b1;
        specValUnp = QNAN;
      end else if (aInf || bZero) begin
        specialUnp = 1'b1;
        specValUnp = {sa ^ sb, 8'hFF, 23'd0};
      end else if (aZero || bInf) begin
        specialUnp = 1'b1;
        specValUnp = {sa ^ sb, 31'd0};
      end
    end else begin
      if (aNaN || (sa && !aZero)) begin
        specialUnp = 1'b1;
        specValUnp = QNAN;
      end else if (aZero) begin
        specialUnp = 1'b1;
        specValUnp = {sa, 31'd0};
      end else if (aInf) begin
        specialUnp = 1'b1;
        specValUnp = 32'h7F800000;
      end
    end
`ifdef FP_DIVSQRT_EARLY_OUT_EN
    if (!specialUnp && isDiv_q && (rhs_q[30:0] == 31'h3F800000)) begin
      specialUnp = 1'b1;
      specValUnp = {sa ^ sb, aZero ? 31'd0 : lhs_q[30:0]};
    end
    earlyOut = specialUnp;
`endif
  end

  logic [28:0] remStep;
  logic [26:0] quotStep;
  logic [53:0] radStep;
  logic [30:0] sqTmp, sqTrial;

  // RADIX_BITS restoring steps per cycle; digits past the 27th are not computed,
  // the nonzero remainder already carries them into sticky.
  always_comb begin
    remStep  = rem_q;
    quotStep = quot_q;
    radStep  = rad_q;
    sqTmp    = 31'd0;
    sqTrial  = 31'd0;
    for (int j = 0; j < RADIX_BITS; j++) begin
      if ((int'(cnt_q) * RADIX_BITS + j) < 27) begin
        if (isDiv_q) begin
          if (remStep >= {5'd0, divisor_q}) begin
            remStep  = remStep - {5'd0, divisor_q};
            quotStep = {quotStep[25:0], 1'b1};
          end else begin
            quotStep = {quotStep[25:0], 1'b0};
          end
          remStep = {remStep[27:0], 1'b0};
        end else begin
          sqTmp   = {remStep, radStep[53:52]};
          sqTrial = {2'b00, quotStep, 2'b01};
          if (sqTmp >= sqTrial) begin
            sqTmp    = sqTmp - sqTrial;
            quotStep = {quotStep[25:0], 1'b1};
          end else begin
            quotStep = {quotStep[25:0], 1'b0};
          end
          remStep = sqTmp[28:0];
          radStep = {radStep[51:0], 2'b00};
        end
      end
    end
  end

  logic [23:0]       mant;
  logic [24:0]       mantR;
  logic              guardBit, stickyBit, roundUp;
  logic signed [9:0] expN, expR;
  logic [22:0]       fracR;
  logic [31:0]       roundRes;

  // Normalize (quotient may sit one bit low), round to nearest even, then range-check.
  always_comb begin
    if (quot_q[26]) begin
      mant      = quot_q[26:3];
      guardBit  = quot_q[2];
      stickyBit = (|quot_q[1:0]) || (rem_q != 29'd0);
      expN      = exp_q;
    end else begin
      mant      = quot_q[25:2];
      guardBit  = quot_q[1];
      stickyBit = quot_q[0] || (rem_q != 29'd0);
      expN      = exp_q - 10'sd1;
    end
    roundUp = guardBit && (stickyBit || mant[0]);
    mantR   = {1'b0, mant} + {24'd0, roundUp};
    if (mantR[24]) begin
      expR  = expN + 10'sd1;
      fracR = mantR[23:1];
    end else begin
      expR  = expN;
      fracR = mantR[22:0];
    end
    if (special_q)           roundRes = specVal_q;
    else if (expR >= 10'sd255) roundRes = {sign_q, 8'hFF, 23'd0};
    else if (expR <= 10'sd0)   roundRes = {sign_q, 31'd0};
    else                       roundRes = {sign_q, expR[7:0], fracR};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Early-out enters the final loop cycle so its latency stays at three cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (ctrl_io.req) state_d = UNPACK;
      UNPACK:     state_d = ITER;
      ITER:       if (cnt_q == LAST_CNT) state_d = ROUND;
      ROUND:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lhs_q      <= 32'h0;
      rhs_q      <= 32'h0;
      isDiv_q    <= 1'b0;
      cnt_q      <= 5'd0;
      rem_q      <= 29'd0;
      quot_q     <= 27'd0;
      rad_q      <= 54'd0;
      divisor_q  <= 24'd0;
      exp_q      <= 10'sd0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      specVal_q  <= 32'h0;
      finished_q <= 1'b0;
      result_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (ctrl_io.req) begin
            lhs_q      <= ctrl_io.lhs;
            rhs_q      <= ctrl_io.rhs;
            isDiv_q    <= ctrl_io.is_divide;
            finished_q <= 1'b0;
          end
        end
        UNPACK: begin
          rem_q     <= isDiv_q ? {5'd0, ma} : 29'd0;
          quot_q    <= 27'd0;
          rad_q     <= sqrtOdd ? {ma, 1'b0, 29'd0} : {1'b0, ma, 29'd0};
          divisor_q <= mb;
          exp_q     <= expUnp;
          sign_q    <= isDiv_q ? (sa ^ sb) : sa;
          special_q <= specialUnp;
          specVal_q <= specValUnp;
          cnt_q     <= earlyOut ? LAST_CNT : 5'd0;
        end
        ITER: begin
          rem_q  <= remStep;
          quot_q <= quotStep;
          rad_q  <= radStep;
          cnt_q  <= cnt_q + 5'd1;
        end
        ROUND: begin
          result_q   <= roundRes;
          finished_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ctrl_io.finished = finished_q;
  assign ctrl_io.result   = result_q;
endmodule
